// File: rtl/pixel_link_pkg.sv
// Shared types and helpers for the 16-bit pixel link (encoder side).
// Holds the encoder FSM state enum, default line geometry and the RGB444->RGB565 expansion.
package pixel_link_pkg;

  localparam int DEF_H_PIXELS = 320;
  localparam int DEF_V_LINES  = 240;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_GAP    = 2'd3
  } enc_state_t;

  typedef logic [11:0] rgb444_t;
  typedef logic [15:0] rgb565_t;

  // MSB replication keeps full-scale white at 16'hFFFF and lets the receiver
  // recover the 4-bit channels from the top bits of each field.
  function automatic rgb565_t rgb444_to_565(input rgb444_t p);
    return {p[11:8], p[11], p[7:4], p[7:6], p[3:0], p[3]};
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through FIFO: dout always shows the oldest entry.
// Synchronous active-low reset empties the FIFO; DEPTH must be a power of two.
module pixel_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_encoder.sv
// Line-buffered RGB444 -> RGB565 burst encoder: one gapless valid run per buffered line.
// Define LINE_HEADER_EN to prefix every burst with a line-number header word.
module pixel_encoder
  import pixel_link_pkg::*;
#(
  parameter int H_PIXELS   = DEF_H_PIXELS,
  parameter int V_LINES    = DEF_V_LINES,
  parameter int FIFO_DEPTH = 1024,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [11:0] axiid,
  output logic        axiir,
  output logic        axiov,
  output logic [15:0] axiod,
  output logic [15:0] line_y,
  output logic        overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(H_PIXELS + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  // Handshake: a pixel is taken on any edge where axiiv && axiir; axiir is low
  // while the FIFO is full or reset is asserted, and the producer may not stall us.
  // Output side has no ready: axiov stays high for the whole burst.
  enc_state_t    state, state_d;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  rgb444_t       fifo_head;
  logic [WW-1:0] word_cnt, word_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic [15:0]   line_cnt, line_d, line_y_d, axiod_d;
  logic          axiov_d;
  logic          line_ready;

  assign axiir      = rst && !fifo_full;
  assign fifo_push  = axiiv && axiir;
  assign line_ready = (fifo_count >= CW'(H_PIXELS)) && !fifo_empty;

  pixel_fifo #(
    .WIDTH (12),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (axiid),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The state names what the output register holds during that cycle, so each
  // decision below loads the word that appears on the following cycle.
  always_comb begin
    state_d  = state;
    axiov_d  = 1'b0;
    axiod_d  = '0;
    line_y_d = line_y;
    line_d   = line_cnt;
    word_d   = word_cnt;
    gap_d    = gap_cnt;
    fifo_pop = 1'b0;
    case (state)
      ST_IDLE: begin
        if (line_ready) begin
          line_y_d = line_cnt;
          axiov_d  = 1'b1;
`ifdef LINE_HEADER_EN
          state_d  = ST_HEADER;
          axiod_d  = line_cnt;
`else
          state_d  = ST_DATA;
          fifo_pop = 1'b1;
          axiod_d  = rgb444_to_565(fifo_head);
          word_d   = WW'(1);
`endif
        end
      end
`ifdef LINE_HEADER_EN
      ST_HEADER: begin
        state_d  = ST_DATA;
        fifo_pop = 1'b1;
        axiov_d  = 1'b1;
        axiod_d  = rgb444_to_565(fifo_head);
        word_d   = WW'(1);
      end
`endif
      ST_DATA: begin
        if (word_cnt < WW'(H_PIXELS) && !fifo_empty) begin
          fifo_pop = 1'b1;
          axiov_d  = 1'b1;
          axiod_d  = rgb444_to_565(fifo_head);
          word_d   = word_cnt + 1'b1;
        end else begin
          state_d = ST_GAP;
          gap_d   = GW'(GAP_CYCLES - 1);
          line_d  = (line_cnt == 16'(V_LINES - 1)) ? 16'd0 : line_cnt + 16'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_d = ST_IDLE;
        else               gap_d   = gap_cnt - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      axiov    <= 1'b0;
      axiod    <= '0;
      line_y   <= '0;
      line_cnt <= '0;
      word_cnt <= '0;
      gap_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      axiov    <= axiov_d;
      axiod    <= axiod_d;
      line_y   <= line_y_d;
      line_cnt <= line_d;
      word_cnt <= word_d;
      gap_cnt  <= gap_d;
      if (axiiv && !axiir) overflow <= 1'b1;
    end
  end

endmodule
